// File: rtl/qdi_pkg.sv
// Shared 1-of-4 QDI definitions: rail constants, FSM state types and the
// binary <-> one-hot rail mapping used by both directions of the bridge.
package qdi_pkg;

  localparam logic [3:0] NEUTRAL_1OF4 = 4'b0000;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_RTZ  = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_WAIT = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  function automatic logic [3:0] encode_1of4(input logic [1:0] word);
    logic [3:0] rails;
    rails = NEUTRAL_1OF4;
    case (word)
      2'd0: rails = 4'b0001;
      2'd1: rails = 4'b0010;
      2'd2: rails = 4'b0100;
      2'd3: rails = 4'b1000;
      default: rails = NEUTRAL_1OF4;
    endcase
    return rails;
  endfunction

  function automatic logic [1:0] decode_1of4(input logic [3:0] rails);
    logic [1:0] word;
    word = 2'd0;
    case (rails)
      4'b0010: word = 2'd1;
      4'b0100: word = 2'd2;
      4'b1000: word = 2'd3;
      default: word = 2'd0;
    endcase
    return word;
  endfunction

  function automatic logic is_1of4(input logic [3:0] rails);
    return (rails == 4'b0001) || (rails == 4'b0010) ||
           (rails == 4'b0100) || (rails == 4'b1000);
  endfunction

endpackage

// File: rtl/qdi2bin_1of4.sv
// Receive side: waits for a stable 1-of-4 token, presents it as binary with a
// valid strobe, and drops the enable until the sender returns to neutral.
module qdi2bin_1of4
  import qdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rx,
  output logic [1:0] rx_data,
  output logic       rx_valid,
  output logic       rxe
);

  logic [3:0] rx_sync;
  logic [3:0] rx_prev_reg;
  logic [1:0] data_reg, data_next;
  rx_state_t  state_reg, state_next;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(4)) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RX_WAIT;
      data_reg    <= 2'd0;
      rx_prev_reg <= NEUTRAL_1OF4;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      rx_prev_reg <= rx_sync;
    end
  end

  // Requiring two identical samples filters rails that are still settling.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    if (state_reg == RX_WAIT) begin
      if (is_1of4(rx_sync) && (rx_sync == rx_prev_reg)) begin
        data_next  = decode_1of4(rx_sync);
        state_next = RX_ACK;
      end
    end else begin
      if (rx_sync == NEUTRAL_1OF4) begin
        state_next = RX_WAIT;
      end
    end
  end

  assign rx_data  = data_reg;
  assign rx_valid = (state_reg == RX_ACK);
  assign rxe      = (state_reg == RX_WAIT);

endmodule

// File: rtl/sync_ff.sv
// Multi-flop synchronizer chain for signals arriving from outside the clock
// domain; also used with d tied high as a reset-release synchronizer.
module sync_ff #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES*WIDTH-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[(SYNC_STAGES-1)*WIDTH-1:0], d};
    end
  end

  assign q = chain_reg[SYNC_STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/bin2qdi_1of4.sv
// Clocked bridge between a level-handshake binary domain and 1-of-4 QDI
// channels: TX encoder FSM here, RX decoder in qdi2bin_1of4.
module bin2qdi_1of4
  import qdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire        VDD,
  inout  wire        GND,
  input  logic [1:0] TxData,
  input  logic       go,
  input  logic       Txe,
  output logic [3:0] Tx,
  input  logic [3:0] Rx,
  output logic [1:0] RxData,
  output logic       RxValid,
  output logic       Rxe
);

  logic      rst_n;
  logic      txe_sync;
  logic      unused_supply;
  tx_state_t state_reg, state_next;
  logic [3:0] tx_reg, tx_next;
  logic      armed_reg, armed_next;

  assign unused_supply = VDD ^ GND;

  // Assertion is immediate; release is aligned to CLK.
  sync_ff #(.SYNC_STAGES(2), .WIDTH(1)) u_rst_sync (
    .clk  (CLK),
    .rst_n(RESET),
    .d    (1'b1),
    .q    (rst_n)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(1)) u_txe_sync (
    .clk  (CLK),
    .rst_n(rst_n),
    .d    (Txe),
    .q    (txe_sync)
  );

  // armed clears in reset so a go held through reset cannot launch a token.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TX_IDLE;
      tx_reg    <= NEUTRAL_1OF4;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tx_next    = tx_reg;
    armed_next = armed_reg | ~go;
    case (state_reg)
      TX_IDLE: begin
        if (go && armed_reg && txe_sync) begin
          tx_next    = encode_1of4(TxData);
          armed_next = 1'b0;
          state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (!txe_sync) begin
          tx_next    = NEUTRAL_1OF4;
          state_next = TX_RTZ;
        end
      end
      TX_RTZ: begin
        if (txe_sync) begin
          state_next = TX_IDLE;
        end
      end
      default: begin
        tx_next    = NEUTRAL_1OF4;
        state_next = TX_IDLE;
      end
    endcase
  end

  assign Tx = tx_reg;

  qdi2bin_1of4 #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk     (CLK),
    .rst_n   (rst_n),
    .rx      (Rx),
    .rx_data (RxData),
    .rx_valid(RxValid),
    .rxe     (Rxe)
  );

endmodule

// File: tb/tb_bin2qdi_1of4.sv
// Directed bench for bin2qdi_1of4: behavioural reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_bin2qdi_1of4;

  localparam int N = 2;

  logic       CLK;
  logic       RESET;
  wire        VDD = 1'b1;
  wire        GND = 1'b0;
  logic [1:0] TxData;
  logic       go;
  logic       Txe;
  logic [3:0] Tx;
  logic [3:0] Rx;
  logic [1:0] RxData;
  logic       RxValid;
  logic       Rxe;

  logic       loop;
  logic       txe_drv;
  logic [3:0] rx_drv;

  assign Txe = loop ? Rxe : txe_drv;
  assign Rx  = loop ? Tx  : rx_drv;

  bin2qdi_1of4 #(.SYNC_STAGES(N)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .VDD    (VDD),
    .GND    (GND),
    .TxData (TxData),
    .go     (go),
    .Txe    (Txe),
    .Tx     (Tx),
    .Rx     (Rx),
    .RxData (RxData),
    .RxValid(RxValid),
    .Rxe    (Rxe)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synchronizers are delay lines of sampled inputs; the
  // channel rules are tracked as "token out", "returning" and "token held".
  logic       m_txe [N];
  logic [3:0] m_rx  [N];
  int         m_rel;
  logic [3:0] m_tx;
  logic       m_out, m_ret, m_armed;
  logic [3:0] m_prev;
  logic [1:0] m_data;
  logic       m_valid;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_rel <= 0;
      for (int i = 0; i < N; i++) begin
        m_txe[i] <= 1'b0;
        m_rx[i]  <= 4'b0;
      end
      m_tx <= 4'b0; m_out <= 1'b0; m_ret <= 1'b0; m_armed <= 1'b0;
      m_prev <= 4'b0; m_data <= 2'd0; m_valid <= 1'b0;
    end else if (m_rel < 2) begin
      m_rel <= m_rel + 1;
    end else begin
      m_txe[0] <= Txe;
      m_rx[0]  <= Rx;
      for (int i = 1; i < N; i++) begin
        m_txe[i] <= m_txe[i-1];
        m_rx[i]  <= m_rx[i-1];
      end
      if (!go) m_armed <= 1'b1;
      if (m_out) begin
        if (!m_txe[N-1]) begin
          m_tx <= 4'b0; m_out <= 1'b0; m_ret <= 1'b1;
        end
      end else if (m_ret) begin
        if (m_txe[N-1]) m_ret <= 1'b0;
      end else if (go && m_armed && m_txe[N-1]) begin
        m_tx <= 4'b0001 << TxData; m_out <= 1'b1; m_armed <= 1'b0;
      end
      m_prev <= m_rx[N-1];
      if (!m_valid) begin
        if ($countones(m_rx[N-1]) == 1 && m_rx[N-1] == m_prev) begin
          m_valid <= 1'b1;
          m_data  <= 2'($clog2(m_rx[N-1]));
        end
      end else if (m_rx[N-1] == 4'b0) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) chk("cycle", {24'd0, Tx, RxData, RxValid, Rxe}, {24'd0, m_tx, m_data, m_valid, !m_valid});
  end

  // Token monitors for the literal scenario checks.
  logic [3:0] tx_seen [$];
  logic [1:0] rx_seen [$];
  logic [3:0] tx_last;
  logic       valid_last;

  always @(negedge CLK) begin
    if (chk_en) begin
      if (Tx != 4'b0 && tx_last == 4'b0) tx_seen.push_back(Tx);
      if (RxValid && !valid_last) rx_seen.push_back(RxData);
    end
    tx_last    <= Tx;
    valid_last <= RxValid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  logic [3:0] exp_tx [4];
  logic [1:0] exp_rx [4];

  initial begin
    exp_tx = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_rx = '{2'd0, 2'd1, 2'd2, 2'd3};
    RESET = 1'b1; TxData = 2'd0; go = 1'b0; loop = 1'b1; txe_drv = 1'b1; rx_drv = 4'b0;
    #1 RESET = 1'b0;

    // 1: reset
    tick(3);
    chk_en = 1'b1;
    tick(97);
    chk("reset_tx", {28'd0, Tx}, 32'd0);
    chk("reset_rxe", {31'd0, Rxe}, 32'd1);
    chk("reset_rxvalid", {31'd0, RxValid}, 32'd0);
    RESET = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("post_release", {26'd0, Tx, RxValid, Rxe}, 32'd1);
    end

    // 2: loopback, four words
    tx_seen.delete(); rx_seen.delete();
    for (int w = 0; w < 4; w++) begin
      TxData = 2'(w);
      go = 1'b1;
      tick(2);
      go = 1'b0;
      tick(40);
      chk("neutral_between", {28'd0, Tx}, 32'd0);
    end
    chk("loop_tx_count", tx_seen.size(), 32'd4);
    chk("loop_rx_count", rx_seen.size(), 32'd4);
    for (int i = 0; i < 4 && i < tx_seen.size(); i++) chk("loop_tx_token", {28'd0, tx_seen[i]}, {28'd0, exp_tx[i]});
    for (int i = 0; i < 4 && i < rx_seen.size(); i++) chk("loop_rx_word", {30'd0, rx_seen[i]}, {30'd0, exp_rx[i]});

    // 3: held go sends one token
    tx_seen.delete();
    TxData = 2'd3;
    go = 1'b1;
    tick(150);
    chk("held_go_count", tx_seen.size(), 32'd1);
    if (tx_seen.size() > 0) chk("held_go_token", {28'd0, tx_seen[0]}, 32'h8);
    go = 1'b0;
    tick(5);

    // 4: multi-hot ignored, then a clean token
    loop = 1'b0; txe_drv = 1'b1; rx_drv = 4'b0011;
    tick(10);
    chk("multihot_rxvalid", {31'd0, RxValid}, 32'd0);
    chk("multihot_rxe", {31'd0, Rxe}, 32'd1);
    rx_drv = 4'b0100;
    for (int i = 0; i < 10 && !RxValid; i++) tick(1);
    chk("token_rxvalid", {31'd0, RxValid}, 32'd1);
    chk("token_rxdata", {30'd0, RxData}, 32'd2);
    chk("token_rxe", {31'd0, Rxe}, 32'd0);
    rx_drv = 4'b0000;
    for (int i = 0; i < 10 && RxValid; i++) tick(1);
    chk("neutral_rxvalid", {31'd0, RxValid}, 32'd0);
    chk("neutral_rxe", {31'd0, Rxe}, 32'd1);

    // 6: stalled acknowledge keeps the token on the rails
    TxData = 2'd1;
    go = 1'b1;
    tick(1);
    chk("stall_launch", {28'd0, Tx}, 32'h2);
    tick(50);
    chk("stall_hold", {28'd0, Tx}, 32'h2);

    // 5: reset mid-handshake, go held through release
    RESET = 1'b0;
    #1;
    chk("async_reset_tx", {28'd0, Tx}, 32'd0);
    tick(10);
    RESET = 1'b1;
    tx_seen.delete();
    tick(20);
    chk("no_token_after_reset", tx_seen.size(), 32'd0);
    chk("idle_after_reset", {28'd0, Tx}, 32'd0);
    go = 1'b0;
    tick(1);
    TxData = 2'd2;
    go = 1'b1;
    tick(1);
    chk("rearm_token", {28'd0, Tx}, 32'h4);
    go = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
